// File: rtl/seg_scan_pkg.sv
// ---------------------------------------------------------------------------
// seg_scan_pkg
//   Shared definitions for the 8-digit 7-segment scanner:
//     - the all-off / none-selected output constants for either polarity
//     - the 16-entry hex-to-segment table (active-low, bit order g..a)
//     - the display-state record held in the shadow and active registers
//   No ports; imported by seg_scan and hex_to_seg7.
// ---------------------------------------------------------------------------
package seg_scan_pkg;

  // Active-low 7-segment patterns, element i is the pattern for hex digit i.
  // Bit order within each entry is g,f,e,d,c,b,a (bit 6 down to bit 0).
  localparam logic [15:0][6:0] HEX_SEG7_TABLE = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  // Everything held by one display snapshot: eight hex digits plus masks.
  typedef struct packed {
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [7:0]  blank;
  } dispState_t;

  // Segment byte with every segment and the decimal point dark.
  function automatic logic [7:0] segAllOff(input bit actLow);
    return actLow ? 8'hFF : 8'h00;
  endfunction

  // Select byte with no digit enabled.
  function automatic logic [7:0] selNone(input bit actLow);
    return actLow ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/seg_scan_hex.sv
// ---------------------------------------------------------------------------
// hex_to_seg7
//   Purely combinational hex-digit to 7-segment decoder.
//   Ports:
//     hex_i  in  4  hex value 0-F
//     seg_o  out 7  active-low segments, bit order g,f,e,d,c,b,a
// ---------------------------------------------------------------------------
module hex_to_seg7
  import seg_scan_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG7_TABLE[hex_i];

endmodule

// File: rtl/seg_scan.sv
// ---------------------------------------------------------------------------
// seg_scan
//   Time-multiplexed 8-digit 7-segment scanner feeding the 74HC595 driver.
//   A divider splits time into slots of SCAN_CNT cycles; each slot drives one
//   digit, with the first BLANK_CNT cycles dark to avoid ghosting. Display
//   values are staged in shadow registers and copied into the active set only
//   at the frame boundary, so a frame never mixes old and new digits.
//   Ports:
//     clk          in   1   system clock
//     reset        in   1   asynchronous reset, active-high
//     digits       in   32  digit i = digits[4i+3:4i]
//     dp_mask      in   8   bit i lights the decimal point of digit i
//     blank_mask   in   8   bit i blanks digit i for its whole slot
//     update       in   1   strobe: capture digits/masks into the shadow set
//     seg          out  8   {dp,g,f,e,d,c,b,a}, registered
//     sel          out  8   one-hot digit select, registered
//     frame_start  out  1   high on the divider wrap where slot 7 -> slot 0
// ---------------------------------------------------------------------------
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int SCAN_CNT    = 50000,
  parameter int BLANK_CNT   = 500,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit SEL_ACT_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] digits,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  blank_mask,
  input  logic        update,
  output logic [7:0]  seg,
  output logic [7:0]  sel,
  output logic        frame_start
);

  localparam int DIV_W = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(SCAN_CNT - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CNT);
  localparam logic [7:0] SEG_OFF  = segAllOff(SEG_ACT_LOW);
  localparam logic [7:0] SEL_NONE = selNone(SEL_ACT_LOW);

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  dispState_t       shadow_q, shadow_d;
  dispState_t       active_q, active_d;
  logic [7:0]       seg_q, seg_d;
  logic [7:0]       sel_q, sel_d;

  dispState_t dispIn;
  logic       slotWrap;
  logic       frameWrap;
  logic [3:0] curHex;
  logic [6:0] curSeg7;
  logic [7:0] segActLow;
  logic [7:0] selOneHot;

  assign dispIn = {digits, dp_mask, blank_mask};
  assign curHex = active_q.digits[{idx_q, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .hex_i (curHex),
    .seg_o (curSeg7)
  );

  // Next-state logic: divider/slot stepping, shadow staging, frame-boundary
  // copy into the active set, and the per-slot output bytes. The output bytes
  // are built from the current div/idx so they appear one clock later.
  always_comb begin
    slotWrap  = (div_q == DIV_MAX);
    frameWrap = slotWrap && (idx_q == 3'd7);

    div_d = slotWrap ? '0 : div_q + DIV_W'(1);
    idx_d = slotWrap ? idx_q + 3'd1 : idx_q;

    shadow_d = update ? dispIn : shadow_q;

    // A strobe landing on the boundary cycle goes straight to the active set,
    // otherwise it would miss this frame and wait a whole extra frame.
    active_d = active_q;
    if (frameWrap) begin
      active_d = update ? dispIn : shadow_q;
    end

    // Table is active-low; a lit decimal point clears bit 7.
    segActLow = {~active_q.dp[idx_q], curSeg7};
    selOneHot = 8'b0000_0001 << idx_q;

    seg_d = SEG_OFF;
    sel_d = SEL_NONE;
    if ((div_q >= BLANK_END) && !active_q.blank[idx_q]) begin
      seg_d = SEG_ACT_LOW ? segActLow : ~segActLow;
      sel_d = SEL_ACT_LOW ? ~selOneHot : selOneHot;
    end
  end

  // State and output registers. Reset forces the display dark at once and
  // restarts the scan at slot 0 with an all-zero display.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      seg_q    <= SEG_OFF;
      sel_q    <= SEL_NONE;
    end else begin
      div_q    <= div_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      seg_q    <= seg_d;
      sel_q    <= sel_d;
    end
  end

  assign seg         = seg_q;
  assign sel         = sel_q;
  assign frame_start = frameWrap;

endmodule
